// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Forwarding-select encodings, multi-cycle FSM state type and the default
// register-address width.
package pipe_pkg;

    localparam int RA_W_DEF = 5;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand forwarding compare for one source register.
// MEM result wins over WB result; register 0 is never forwarded.
// Only instantiated when HAZARD_FWD_EN is defined.
module fwd_unit
    import pipe_pkg::*;
#(
    parameter int RA_W = RA_W_DEF
) (
    input  logic [RA_W-1:0] ex_r,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_regwrite,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_regwrite,
    output logic [1:0]      fwd
);

    // Pick the youngest in-flight producer of ex_r.
    always_comb begin
        fwd = FWD_NONE;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_r)) begin
            fwd = FWD_MEM;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_r)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller for the 5-stage CPU.
// Generates stall/flush controls for PC, IF/ID, ID/EX, EX/MEM and the EX
// operand forwarding selects, and holds the pipeline while a fixed-latency
// mul/div occupies EX (RUN/BUSY FSM plus down-counter).
// Build option: HAZARD_FWD_EN defined -> operand forwarding with load-use
// interlock only; undefined -> no forwarding, interlock on any EX/MEM
// producer that ID reads.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MD_LAT = 8,
    parameter int RA_W   = RA_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic [RA_W-1:0] ex_rs,
    input  logic [RA_W-1:0] ex_rt,
    input  logic [RA_W-1:0] ex_rd,
    input  logic [RA_W-1:0] mem_rd,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            ex_regwrite,
    input  logic            mem_regwrite,
    input  logic            wb_regwrite,
    input  logic            ex_memread,
    input  logic            ex_branch_taken,
    input  logic            ex_md_start,
    output logic            stall_f,
    output logic            stall_d,
    output logic            stall_e,
    output logic            flush_d,
    output logic            flush_e,
    output logic            flush_m,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            md_busy,
    output logic            md_done
);

    localparam int                CNT_W    = $clog2(MD_LAT);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       id_dep_ex;
    logic       load_use;
    logic       raw_hazard;
    logic [1:0] fwd_a_c, fwd_b_c;
    logic       st_f, st_d, st_e, fl_d, fl_e, fl_m, done_c;

    assign id_dep_ex = (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
    assign load_use  = ex_memread && id_dep_ex;

`ifdef HAZARD_FWD_EN
    logic unused_inputs;
    assign unused_inputs = ex_regwrite;

    assign raw_hazard = load_use;

    fwd_unit #(.RA_W(RA_W)) u_fwd_a (
        .ex_r         (ex_rs),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .fwd          (fwd_a_c)
    );

    fwd_unit #(.RA_W(RA_W)) u_fwd_b (
        .ex_r         (ex_rt),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .fwd          (fwd_b_c)
    );
`else
    // WB needs no interlock: the register file is write-first.
    logic unused_inputs;
    logic id_dep_mem;
    assign unused_inputs = ^{ex_rs, ex_rt, wb_rd, wb_regwrite};
    assign id_dep_mem    = (mem_rd != '0) && ((mem_rd == id_rs) || (mem_rd == id_rt));
    assign raw_hazard    = load_use || (ex_regwrite && id_dep_ex) ||
                           (mem_regwrite && id_dep_mem);
    assign fwd_a_c       = FWD_NONE;
    assign fwd_b_c       = FWD_NONE;
`endif

    // FSM next state and raw control outputs; branch beats mul/div start,
    // mul/div start beats data hazards, BUSY beats everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        st_f    = 1'b0;
        st_d    = 1'b0;
        st_e    = 1'b0;
        fl_d    = 1'b0;
        fl_e    = 1'b0;
        fl_m    = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            RUN: begin
                if (ex_branch_taken) begin
                    fl_d = 1'b1;
                    fl_e = 1'b1;
                end else if (ex_md_start) begin
                    st_f    = 1'b1;
                    st_d    = 1'b1;
                    st_e    = 1'b1;
                    fl_m    = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end else if (raw_hazard) begin
                    st_f = 1'b1;
                    st_d = 1'b1;
                    fl_e = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q > CNT_ONE) begin
                    st_f  = 1'b1;
                    st_d  = 1'b1;
                    st_e  = 1'b1;
                    fl_m  = 1'b1;
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    // Final EX cycle: let the mul/div advance out of EX.
                    done_c  = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
        if (rst) begin
            state_d = RUN;
            cnt_d   = '0;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // All outputs are forced low while reset is asserted.
    assign stall_f = ~rst & st_f;
    assign stall_d = ~rst & st_d;
    assign stall_e = ~rst & st_e;
    assign flush_d = ~rst & fl_d;
    assign flush_e = ~rst & fl_e;
    assign flush_m = ~rst & fl_m;
    assign md_done = ~rst & done_c;
    assign md_busy = ~rst & (state_q == BUSY);
    assign fwd_a   = rst ? FWD_NONE : fwd_a_c;
    assign fwd_b   = rst ? FWD_NONE : fwd_b_c;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Two instances share inputs:
// index 0 with MD_LAT=8, index 1 with MD_LAT=2. Follows HAZARD_FWD_EN the
// same way the design does.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       ex_regwrite, mem_regwrite, wb_regwrite;
    logic       ex_memread, ex_branch_taken, ex_md_start;

    logic [1:0] stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
    logic [1:0] md_busy, md_done;
    logic [1:0] fwd_a [2];
    logic [1:0] fwd_b [2];

    int errors = 0;
    int checks = 0;

    // Output vector layout: sf sd se fd fe fm | fa | fb | busy done
    localparam logic [11:0] E_IDLE     = 12'b000000_00_00_0_0;
    localparam logic [11:0] E_LOADUSE  = 12'b110010_00_00_0_0;
    localparam logic [11:0] E_BRANCH   = 12'b000110_00_00_0_0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_LAT(8), .RA_W(5)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite),
        .wb_regwrite(wb_regwrite), .ex_memread(ex_memread),
        .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
        .stall_f(stall_f[0]), .stall_d(stall_d[0]), .stall_e(stall_e[0]),
        .flush_d(flush_d[0]), .flush_e(flush_e[0]), .flush_m(flush_m[0]),
        .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]),
        .md_busy(md_busy[0]), .md_done(md_done[0])
    );

    hazard_ctrl #(.MD_LAT(2), .RA_W(5)) dut2 (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite),
        .wb_regwrite(wb_regwrite), .ex_memread(ex_memread),
        .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
        .stall_f(stall_f[1]), .stall_d(stall_d[1]), .stall_e(stall_e[1]),
        .flush_d(flush_d[1]), .flush_e(flush_e[1]), .flush_m(flush_m[1]),
        .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]),
        .md_busy(md_busy[1]), .md_done(md_done[1])
    );

    function automatic logic [11:0] obs(input int i);
        return {stall_f[i], stall_d[i], stall_e[i], flush_d[i], flush_e[i],
                flush_m[i], fwd_a[i], fwd_b[i], md_busy[i], md_done[i]};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic id_reads(input logic [4:0] r);
        return (r != 5'd0) && ((r == id_rs) || (r == id_rt));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] r);
`ifdef HAZARD_FWD_EN
        if (mem_regwrite && mem_rd != 5'd0 && mem_rd == r) return 2'b10;
        if (wb_regwrite && wb_rd != 5'd0 && wb_rd == r) return 2'b01;
        return 2'b00;
`else
        return (r === 5'bx) ? 2'b11 : 2'b00;
`endif
    endfunction

    // age = how many EX cycles the current mul/div has already spent (0: none).
    function automatic logic [11:0] model(input int lat, input int age, output int nage);
        int   p;
        logic haz, load;
        logic s, fd, fe, hz, busy, done;
        load = ex_memread && id_reads(ex_rd);
`ifdef HAZARD_FWD_EN
        haz = load;
`else
        haz = load || (ex_regwrite && id_reads(ex_rd)) || (mem_regwrite && id_reads(mem_rd));
`endif
        s = 0; fd = 0; fe = 0; hz = 0; busy = 0; done = 0;
        nage = 0;
        if (rst) return 12'd0;
        if (age > 0) begin
            p    = age + 1;
            busy = 1'b1;
            s    = (p < lat);
            done = (p == lat);
            nage = (p == lat) ? 0 : p;
        end else if (ex_branch_taken) begin
            fd = 1'b1;
            fe = 1'b1;
        end else if (ex_md_start) begin
            s    = 1'b1;
            nage = 1;
        end else if (haz) begin
            hz = 1'b1;
        end
        return {s | hz, s | hz, s, fd, fe | hz, s, fwd_sel(ex_rs), fwd_sel(ex_rt), busy, done};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_regwrite = 0; mem_regwrite = 0; wb_regwrite = 0;
        ex_memread = 0; ex_branch_taken = 0; ex_md_start = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        ex_memread = 1; ex_rd = 5; id_rs = 5; ex_md_start = 1;
        mem_regwrite = 1; mem_rd = 3; ex_rs = 3;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== E_IDLE) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got %b expected %b", i, obs(i), E_IDLE);
            end
        end
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== E_IDLE) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got %b expected %b", i, obs(i), E_IDLE);
            end
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        ex_memread = 1; ex_rd = 5; id_rs = 5; id_rt = 2;
        #1;
        checks++;
        if (obs(0) !== E_LOADUSE) begin
            errors++;
            $display("FAIL load_use_stall: got %b expected %b", obs(0), E_LOADUSE);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (obs(0) !== E_IDLE) begin
            errors++;
            $display("FAIL load_use_clear: got %b expected %b", obs(0), E_IDLE);
        end
        @(negedge clk);
        ex_memread = 1; ex_rd = 0; id_rs = 0; id_rt = 0;
        #1;
        checks++;
        if (obs(0) !== E_IDLE) begin
            errors++;
            $display("FAIL load_use_r0: got %b expected %b", obs(0), E_IDLE);
        end
    endtask

`ifdef HAZARD_FWD_EN
    task automatic test_forward();
        apply_reset();
        mem_regwrite = 1; mem_rd = 3; wb_regwrite = 1; wb_rd = 3; ex_rs = 3;
        #1;
        checks++;
        if (fwd_a[0] !== 2'b10) begin
            errors++;
            $display("FAIL fwd_mem_priority: got %b expected %b", fwd_a[0], 2'b10);
        end
        @(negedge clk);
        clear_inputs();
        mem_regwrite = 1; mem_rd = 4; ex_rt = 4; ex_rs = 1;
        #1;
        checks++;
        if ({fwd_a[0], fwd_b[0]} !== 4'b0010) begin
            errors++;
            $display("FAIL fwd_mem_b: got %b expected %b", {fwd_a[0], fwd_b[0]}, 4'b0010);
        end
        @(negedge clk);
        clear_inputs();
        wb_regwrite = 1; wb_rd = 6; ex_rs = 6;
        #1;
        checks++;
        if (fwd_a[0] !== 2'b01) begin
            errors++;
            $display("FAIL fwd_wb_only: got %b expected %b", fwd_a[0], 2'b01);
        end
        @(negedge clk);
        clear_inputs();
        mem_regwrite = 1; wb_regwrite = 1;
        #1;
        checks++;
        if ({fwd_a[0], fwd_b[0]} !== 4'b0000) begin
            errors++;
            $display("FAIL fwd_r0: got %b expected %b", {fwd_a[0], fwd_b[0]}, 4'b0000);
        end
    endtask
`else
    task automatic test_interlock();
        apply_reset();
        ex_regwrite = 1; ex_rd = 7; id_rs = 7; ex_rs = 7;
        #1;
        checks++;
        if (obs(0) !== E_LOADUSE) begin
            errors++;
            $display("FAIL interlock_ex: got %b expected %b", obs(0), E_LOADUSE);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (obs(0) !== E_IDLE) begin
            errors++;
            $display("FAIL interlock_clear: got %b expected %b", obs(0), E_IDLE);
        end
        @(negedge clk);
        mem_regwrite = 1; mem_rd = 7; id_rt = 7; ex_rs = 7; ex_rt = 7;
        #1;
        checks++;
        if (obs(0) !== E_LOADUSE) begin
            errors++;
            $display("FAIL interlock_mem: got %b expected %b", obs(0), E_LOADUSE);
        end
        @(negedge clk);
        clear_inputs();
        wb_regwrite = 1; wb_rd = 7; id_rs = 7; ex_rs = 7;
        #1;
        checks++;
        if (obs(0) !== E_IDLE) begin
            errors++;
            $display("FAIL interlock_wb_none: got %b expected %b", obs(0), E_IDLE);
        end
    endtask
`endif

    task automatic test_md_multicycle();
        logic [11:0] exp;
        logic        s;
        apply_reset();
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clk);
            ex_md_start = 1;
            #1;
            s   = (k < 8);
            exp = {s, s, s, 1'b0, 1'b0, s, 4'b0000, (k >= 2), (k == 8)};
            checks++;
            if (obs(0) !== exp) begin
                errors++;
                $display("FAIL md8_cycle%0d: got %b expected %b", k, obs(0), exp);
            end
            if (k <= 2) begin
                s   = (k < 2);
                exp = {s, s, s, 1'b0, 1'b0, s, 4'b0000, (k >= 2), (k == 2)};
                checks++;
                if (obs(1) !== exp) begin
                    errors++;
                    $display("FAIL md2_cycle%0d: got %b expected %b", k, obs(1), exp);
                end
            end
        end
        @(negedge clk);
        ex_md_start = 0;
        #1;
        checks++;
        if (obs(0) !== E_IDLE) begin
            errors++;
            $display("FAIL md8_no_retrigger: got %b expected %b", obs(0), E_IDLE);
        end
    endtask

    task automatic test_branch_priority();
        apply_reset();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5; id_rs = 5;
        ex_branch_taken = 1; ex_md_start = 1;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== E_BRANCH) begin
                errors++;
                $display("FAIL branch_priority[%0d]: got %b expected %b", i, obs(i), E_BRANCH);
            end
        end
        @(negedge clk);
        clear_inputs();
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== E_IDLE) begin
                errors++;
                $display("FAIL branch_no_md[%0d]: got %b expected %b", i, obs(i), E_IDLE);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        apply_reset();
        ex_md_start = 1;
        repeat (4) @(negedge clk);
        rst = 1;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== E_IDLE) begin
                errors++;
                $display("FAIL rst_busy_outputs[%0d]: got %b expected %b", i, obs(i), E_IDLE);
            end
        end
        @(negedge clk);
        rst = 0;
        ex_md_start = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== E_IDLE) begin
                errors++;
                $display("FAIL rst_busy_after[%0d]: got %b expected %b", i, obs(i), E_IDLE);
            end
        end
    endtask

    task automatic test_random();
        int          age8, age2, n8, n2;
        logic [11:0] exp8, exp2;
        apply_reset();
        age8 = 0;
        age2 = 0;
        for (int t = 0; t < 600; t++) begin
            if (t > 0) @(negedge clk);
            rst             = ($urandom_range(0, 40) == 0);
            id_rs           = 5'($urandom_range(0, 7));
            id_rt           = 5'($urandom_range(0, 7));
            ex_rs           = 5'($urandom_range(0, 7));
            ex_rt           = 5'($urandom_range(0, 7));
            ex_rd           = 5'($urandom_range(0, 7));
            mem_rd          = 5'($urandom_range(0, 7));
            wb_rd           = 5'($urandom_range(0, 7));
            ex_regwrite     = $urandom_range(0, 1) == 1;
            mem_regwrite    = $urandom_range(0, 1) == 1;
            wb_regwrite     = $urandom_range(0, 1) == 1;
            ex_memread      = $urandom_range(0, 2) == 0;
            ex_branch_taken = $urandom_range(0, 7) == 0;
            ex_md_start     = $urandom_range(0, 9) == 0;
            #1;
            exp8 = model(8, age8, n8);
            exp2 = model(2, age2, n2);
            checks++;
            if (obs(0) !== exp8) begin
                errors++;
                $display("FAIL random_md8 t=%0d: got %b expected %b", t, obs(0), exp8);
            end
            checks++;
            if (obs(1) !== exp2) begin
                errors++;
                $display("FAIL random_md2 t=%0d: got %b expected %b", t, obs(1), exp2);
            end
            age8 = n8;
            age2 = n2;
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
`ifdef HAZARD_FWD_EN
        test_forward();
`else
        test_interlock();
`endif
        test_md_multicycle();
        test_branch_priority();
        test_reset_mid_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
